// File: rtl/reg_file_rename_mw_if.sv
// Dispatch/commit bundle of the multi-issue rename register file.
// The master side (dispatch plus ROB) drives the requests and reads back the operand ports.
interface reg_file_rename_mw_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int ROB_IDX_W = 4,
  parameter int ISSUE_W   = 2,
  parameter int COMMIT_W  = 2
);
  logic                                 rdy_in;
  logic                                 clr_in;
  logic [ISSUE_W-1:0]                   issue_valid;
  logic [ISSUE_W-1:0][REG_IDX_W-1:0]    issue_rd;
  logic [ISSUE_W-1:0][ROB_IDX_W-1:0]    issue_rob_index;
  logic [2*ISSUE_W-1:0][REG_IDX_W-1:0]  rs_pos;
  logic [2*ISSUE_W-1:0][XLEN-1:0]       rs_val;
  logic [2*ISSUE_W-1:0][ROB_IDX_W-1:0]  rs_depend;
  logic [COMMIT_W-1:0]                  commit_valid;
  logic [COMMIT_W-1:0][ROB_IDX_W-1:0]   commit_rob_index;
  logic [COMMIT_W-1:0][REG_IDX_W-1:0]   commit_rd;
  logic [COMMIT_W-1:0][XLEN-1:0]        commit_val;

  modport master (
    output rdy_in, clr_in, issue_valid, issue_rd, issue_rob_index, rs_pos,
           commit_valid, commit_rob_index, commit_rd, commit_val,
    input  rs_val, rs_depend
  );

  modport slave (
    input  rdy_in, clr_in, issue_valid, issue_rd, issue_rob_index, rs_pos,
           commit_valid, commit_rob_index, commit_rd, commit_val,
    output rs_val, rs_depend
  );
endinterface

// File: rtl/reg_file_rename_mw.sv
// Multi-issue/multi-commit architectural register file with ROB-tag dependency tracking,
// intra-bundle rename forwarding and same-cycle commit bypass on every read port.
module rf_read_port #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int ROB_IDX_W = 4,
  parameter int ISSUE_W   = 2,
  parameter int COMMIT_W  = 2,
  parameter int SLOT      = 0
) (
  input  logic [REG_IDX_W-1:0]               pos,
  input  logic [XLEN-1:0]                    reg_val,
  input  logic [ROB_IDX_W-1:0]               reg_dep,
  input  logic [ISSUE_W-1:0]                 issue_valid,
  input  logic [ISSUE_W-1:0][REG_IDX_W-1:0]  issue_rd,
  input  logic [ISSUE_W-1:0][ROB_IDX_W-1:0]  issue_rob_index,
  input  logic [COMMIT_W-1:0]                commit_valid,
  input  logic [COMMIT_W-1:0][ROB_IDX_W-1:0] commit_rob_index,
  input  logic [COMMIT_W-1:0][XLEN-1:0]      commit_val,
  output logic [XLEN-1:0]                    val,
  output logic [ROB_IDX_W-1:0]               depend
);
  logic                 fwd_hit;
  logic [ROB_IDX_W-1:0] fwd_tag;
  logic                 byp_hit;
  logic [XLEN-1:0]      byp_val;

  // Ascending scans so the highest matching slot wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_tag = '0;
    byp_hit = 1'b0;
    byp_val = '0;
    for (int j = 0; j < ISSUE_W; j++)
      if (j < SLOT && issue_valid[j] && issue_rd[j] == pos) begin
        fwd_hit = 1'b1;
        fwd_tag = issue_rob_index[j];
      end
    for (int c = 0; c < COMMIT_W; c++)
      if (commit_valid[c] && commit_rob_index[c] == reg_dep) begin
        byp_hit = 1'b1;
        byp_val = commit_val[c];
      end
    val    = reg_val;
    depend = reg_dep;
    if (pos == '0) begin
      val    = '0;
      depend = '0;
    end else if (fwd_hit) begin
      val    = '0;
      depend = fwd_tag;
    end else if (reg_dep != '0 && byp_hit) begin
      val    = byp_val;
      depend = '0;
    end
  end
endmodule

module reg_file_rename_mw #(
  parameter int XLEN      = 32,
  parameter int REG_NUM   = 32,
  parameter int REG_IDX_W = 5,
  parameter int ROB_IDX_W = 4,
  parameter int ISSUE_W   = 2,
  parameter int COMMIT_W  = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  reg_file_rename_mw_if.slave bus
);
  logic [REG_NUM-1:0][XLEN-1:0]      val_q, val_n;
  logic [REG_NUM-1:0][ROB_IDX_W-1:0] dep_q, dep_n;
  logic                              y_hit;
  logic [ROB_IDX_W-1:0]              y_tag;

  for (genvar p = 0; p < 2*ISSUE_W; p++) begin : g_port
    rf_read_port #(
      .XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .ROB_IDX_W(ROB_IDX_W),
      .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W), .SLOT(p/2)
    ) u_port (
      .pos              (bus.rs_pos[p]),
      .reg_val          (val_q[bus.rs_pos[p]]),
      .reg_dep          (dep_q[bus.rs_pos[p]]),
      .issue_valid      (bus.issue_valid),
      .issue_rd         (bus.issue_rd),
      .issue_rob_index  (bus.issue_rob_index),
      .commit_valid     (bus.commit_valid),
      .commit_rob_index (bus.commit_rob_index),
      .commit_val       (bus.commit_val),
      .val              (bus.rs_val[p]),
      .depend           (bus.rs_depend[p])
    );
  end

  always_comb begin
    val_n = val_q;
    dep_n = dep_q;
    y_hit = 1'b0;
    y_tag = '0;
    for (int c = 0; c < COMMIT_W; c++)
      if (bus.commit_valid[c] && bus.commit_rd[c] != '0)
        val_n[bus.commit_rd[c]] = bus.commit_val[c];
    // A dep clears only when it still names the youngest committer of that register.
    for (int r = 1; r < REG_NUM; r++) begin
      y_hit = 1'b0;
      y_tag = '0;
      for (int c = 0; c < COMMIT_W; c++)
        if (bus.commit_valid[c] && bus.commit_rd[c] == REG_IDX_W'(r)) begin
          y_hit = 1'b1;
          y_tag = bus.commit_rob_index[c];
        end
      if (y_hit && dep_q[r] == y_tag) dep_n[r] = '0;
    end
    if (bus.clr_in) dep_n = '0;
    else
      for (int j = 0; j < ISSUE_W; j++)
        if (bus.issue_valid[j] && bus.issue_rd[j] != '0)
          dep_n[bus.issue_rd[j]] = bus.issue_rob_index[j];
    val_n[0] = '0;
    dep_n[0] = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q <= '0;
      dep_q <= '0;
    end else if (bus.rdy_in) begin
      val_q <= val_n;
      dep_q <= dep_n;
    end
  end
endmodule

// File: tb/tb_reg_file_rename_mw.sv
// Directed plus randomized bench for reg_file_rename_mw against an array-based reference model.
module tb_reg_file_rename_mw;
  localparam int IW = 2, CW = 2, NP = 2*IW;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  reg_file_rename_mw_if #(.XLEN(32), .REG_IDX_W(5), .ROB_IDX_W(4), .ISSUE_W(IW), .COMMIT_W(CW)) bus ();

  reg_file_rename_mw #(.XLEN(32), .REG_NUM(32), .REG_IDX_W(5), .ROB_IDX_W(4),
                       .ISSUE_W(IW), .COMMIT_W(CW))
    dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus.slave));

  logic [31:0] mval [32];
  logic [3:0]  mdep [32];
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected operand for a port of slot k, straight from the priority rules.
  task automatic read_exp(input int k, input logic [4:0] pos, output logic [31:0] v, output logic [3:0] d);
    bit fh = 0; logic [3:0] ft = 0;
    bit bh = 0; logic [31:0] bv = 0;
    for (int j = 0; j < k; j++)
      if (bus.issue_valid[j] && bus.issue_rd[j] == pos) begin fh = 1; ft = bus.issue_rob_index[j]; end
    for (int c = 0; c < CW; c++)
      if (bus.commit_valid[c] && bus.commit_rob_index[c] == mdep[pos]) begin bh = 1; bv = bus.commit_val[c]; end
    if (pos == 0) begin v = 0; d = 0; end
    else if (fh) begin v = 0; d = ft; end
    else if (mdep[pos] != 0 && bh) begin v = bv; d = 0; end
    else begin v = mval[pos]; d = mdep[pos]; end
  endtask

  task automatic check_ports(input string tag);
    logic [31:0] v; logic [3:0] d;
    #1;
    for (int p = 0; p < NP; p++) begin
      read_exp(p/2, bus.rs_pos[p], v, d);
      chk($sformatf("%s_val_p%0d_x%0d", tag, p, bus.rs_pos[p]), bus.rs_val[p], v);
      chk($sformatf("%s_dep_p%0d_x%0d", tag, p, bus.rs_pos[p]), 32'(bus.rs_depend[p]), 32'(d));
    end
  endtask

  task automatic idle();
    bus.rdy_in = 1; bus.clr_in = 0; rst_in = 0;
    bus.issue_valid = '0; bus.issue_rd = '0; bus.issue_rob_index = '0;
    bus.commit_valid = '0; bus.commit_rd = '0; bus.commit_rob_index = '0; bus.commit_val = '0;
    bus.rs_pos = '0;
  endtask

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    logic [31:0] nv [32]; logic [3:0] nd [32];
    nv = mval; nd = mdep;
    if (rst_in) begin
      for (int r = 0; r < 32; r++) begin nv[r] = 0; nd[r] = 0; end
    end else if (bus.rdy_in) begin
      for (int r = 1; r < 32; r++) begin
        int young = -1;
        for (int c = 0; c < CW; c++)
          if (bus.commit_valid[c] && bus.commit_rd[c] == 5'(r)) young = c;
        if (young >= 0) begin
          nv[r] = bus.commit_val[young];
          if (mdep[r] == bus.commit_rob_index[young]) nd[r] = 0;
        end
      end
      if (bus.clr_in) for (int r = 0; r < 32; r++) nd[r] = 0;
      else
        for (int j = 0; j < IW; j++)
          if (bus.issue_valid[j] && bus.issue_rd[j] != 0) nd[bus.issue_rd[j]] = bus.issue_rob_index[j];
    end
    @(posedge clk_in);
    #1;
    mval = nv; mdep = nd;
  endtask

  task automatic readall(input string tag);
    idle();
    for (int r = 0; r < 32; r += NP) begin
      for (int p = 0; p < NP; p++) bus.rs_pos[p] = 5'(r + p);
      check_ports(tag);
    end
  endtask

  task automatic rd_reg(input logic [4:0] r, output logic [31:0] v, output logic [3:0] d);
    idle();
    bus.rs_pos[0] = r;
    #1;
    v = bus.rs_val[0]; d = bus.rs_depend[0];
  endtask

  task automatic issue(input int s, input logic [4:0] rd, input logic [3:0] tag);
    bus.issue_valid[s] = 1; bus.issue_rd[s] = rd; bus.issue_rob_index[s] = tag;
  endtask

  task automatic commit(input int s, input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
    bus.commit_valid[s] = 1; bus.commit_rd[s] = rd; bus.commit_rob_index[s] = tag; bus.commit_val[s] = v;
  endtask

  initial begin
    logic [31:0] v; logic [3:0] d;
    for (int r = 0; r < 32; r++) begin mval[r] = 'x; mdep[r] = 'x; end
    idle();
    rst_in = 1;
    tick();
    rst_in = 0;
    readall("reset");

    // x0 is immune to commits
    idle(); commit(0, 0, 4'd1, 32'hDEAD); commit(1, 0, 4'd2, 32'hDEAD); tick();
    rd_reg(0, v, d); chk("x0_val", v, 0); chk("x0_dep", 32'(d), 0);

    // intra-bundle forwarding, then stored dep
    idle(); issue(0, 5, 4'd3); bus.rs_pos[2] = 5; bus.rs_pos[0] = 5;
    #1; chk("fwd_p2_dep", 32'(bus.rs_depend[2]), 3); chk("fwd_p0_nofwd", 32'(bus.rs_depend[0]), 0);
    check_ports("fwd");
    tick();
    rd_reg(5, v, d); chk("x5_dep_after_issue", 32'(d), 3);

    // commit bypass from slot 1
    idle(); commit(1, 5, 4'd3, 32'h1234); bus.rs_pos[0] = 5;
    #1; chk("byp_val", bus.rs_val[0], 32'h1234); chk("byp_dep", 32'(bus.rs_depend[0]), 0);
    tick();
    rd_reg(5, v, d); chk("x5_val_commit", v, 32'h1234); chk("x5_dep_commit", 32'(d), 0);

    // issue overrides same-cycle commit clear
    idle(); issue(0, 5, 4'd3); tick();
    idle(); commit(0, 5, 4'd3, 32'h55); issue(0, 5, 4'd7); tick();
    rd_reg(5, v, d); chk("x5_val_ovr", v, 32'h55); chk("x5_dep_ovr", 32'(d), 7);

    // two commits to one rd: youngest tag decides the clear
    idle(); issue(1, 6, 4'd4); tick();
    idle(); commit(0, 6, 4'd2, 1); commit(1, 6, 4'd4, 2); tick();
    rd_reg(6, v, d); chk("x6_val_a", v, 2); chk("x6_dep_a", 32'(d), 0);
    idle(); issue(0, 6, 4'd9); tick();
    idle(); commit(0, 6, 4'd2, 1); commit(1, 6, 4'd4, 2); tick();
    rd_reg(6, v, d); chk("x6_val_b", v, 2); chk("x6_dep_b", 32'(d), 9);

    // flush keeps commits, drops issues, clears deps
    idle(); issue(0, 10, 4'd11); issue(1, 11, 4'd12); tick();
    idle(); bus.clr_in = 1; commit(0, 8, 4'd1, 32'hAA); issue(0, 9, 4'd5); tick();
    rd_reg(8, v, d); chk("x8_val_flush", v, 32'hAA);
    rd_reg(9, v, d); chk("x9_dep_flush", 32'(d), 0);
    rd_reg(10, v, d); chk("x10_dep_flush", 32'(d), 0);
    readall("flush");

    // stall: three cycles of ignored traffic
    idle(); issue(0, 8, 4'd6); issue(1, 12, 4'd7); commit(0, 8, 4'd1, 32'hBAD); commit(1, 13, 4'd2, 32'hBEEF);
    bus.rdy_in = 0;
    repeat (3) tick();
    rd_reg(8, v, d); chk("x8_val_stall", v, 32'hAA); chk("x8_dep_stall", 32'(d), 0);
    rd_reg(13, v, d); chk("x13_val_stall", v, 0);
    readall("stall");

    // reset wins over stall, flush and pending issue
    idle(); issue(0, 14, 4'd3); tick();
    idle(); bus.rdy_in = 0; bus.clr_in = 1; issue(0, 15, 4'd4); commit(0, 16, 4'd1, 32'h77); rst_in = 1; tick();
    rd_reg(8, v, d); chk("x8_val_rst", v, 0);
    rd_reg(14, v, d); chk("x14_dep_rst", 32'(d), 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rst_in = ($urandom_range(0, 99) == 0);
      bus.rdy_in = ($urandom_range(0, 7) != 0);
      bus.clr_in = ($urandom_range(0, 29) == 0);
      for (int j = 0; j < IW; j++)
        if ($urandom_range(0, 2) != 0) issue(j, 5'($urandom_range(0, 7)), 4'($urandom_range(1, 15)));
      for (int c = 0; c < CW; c++)
        if ($urandom_range(0, 1) != 0) begin
          logic [4:0] rd = 5'($urandom_range(0, 7));
          logic [3:0] tg = ($urandom_range(0, 2) != 0 && mdep[rd] != 0) ? mdep[rd] : 4'($urandom_range(1, 15));
          commit(c, rd, tg, $urandom);
        end
      for (int p = 0; p < NP; p++) bus.rs_pos[p] = 5'($urandom_range(0, 8));
      check_ports("rand");
      tick();
      if (n % 100 == 99) readall("rand_state");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
